// File: rtl/regfile_sequencer.sv
// Register-file transfer sequencer: arbitrates fetch and exec requesters
// round-robin and steps each transfer through DRIVE, LOAD and ACK. All outputs
// are registered and are decoded from the state being entered.
module regfile_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fetch_req,
   output logic       fetch_ack,
   input  logic       exec_req,
   input  logic [2:0] exec_src,
   input  logic [2:0] exec_dst,
   output logic       exec_ack,
   output logic [7:0] notOE,
   output logic [7:0] notLoad,
   output logic       pcInc,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

   localparam logic [3:0] LAST_HOLD = 4'(HOLD_CYCLES - 1);
   localparam logic [2:0] PC_IDX    = 3'd7;

   state_t     state, nextState;
   logic [3:0] holdCnt, nextHoldCnt;
   logic       prioExec, nextPrioExec;
   logic       isExec, nextIsExec;
   logic       grantExec;
   logic [2:0] srcIdx, nextSrcIdx;
   logic [2:0] dstIdx, nextDstIdx;
   logic [7:0] nextNotOE, nextNotLoad;
   logic       nextPcInc, nextFetchAck, nextExecAck, nextBusy;

   // Next state, arbitration, operand latching and decode of the registered outputs.
   // Outputs are decoded from the next state and next operands so that the
   // registered values line up with the state they describe.
   always_comb begin
      nextState    = state;
      nextHoldCnt  = holdCnt;
      nextPrioExec = prioExec;
      nextIsExec   = isExec;
      nextSrcIdx   = srcIdx;
      nextDstIdx   = dstIdx;
      grantExec    = 1'b0;

      case (state)
         IDLE: begin
            if (fetch_req || exec_req) begin
               grantExec = exec_req && (!fetch_req || prioExec);
               if (fetch_req && exec_req) begin
                  nextPrioExec = !prioExec;
               end
               nextIsExec  = grantExec;
               nextSrcIdx  = grantExec ? exec_src : PC_IDX;
               nextDstIdx  = grantExec ? exec_dst : PC_IDX;
               nextHoldCnt = '0;
               nextState   = DRIVE;
            end
         end
         DRIVE: begin
            if (holdCnt == LAST_HOLD) begin
               nextHoldCnt = '0;
               nextState   = LOAD;
            end else begin
               nextHoldCnt = holdCnt + 4'd1;
            end
         end
         LOAD:    nextState = ACK;
         ACK:     nextState = IDLE;
         default: nextState = IDLE;
      endcase

      nextNotOE    = '1;
      nextNotLoad  = '1;
      nextPcInc    = 1'b0;
      nextFetchAck = 1'b0;
      nextExecAck  = 1'b0;
      nextBusy     = (nextState != IDLE);

      if (nextState == DRIVE || nextState == LOAD) begin
         nextNotOE[nextSrcIdx] = 1'b0;
      end
      if (nextState == LOAD) begin
         if (nextIsExec) begin
            nextNotLoad[nextDstIdx] = 1'b0;
         end else begin
            nextPcInc = 1'b1;
         end
      end
      if (nextState == ACK) begin
         nextFetchAck = !nextIsExec;
         nextExecAck  = nextIsExec;
      end
   end

   // State, operand and output registers; reset forces the idle values at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         holdCnt   <= '0;
         prioExec  <= 1'b0;
         isExec    <= 1'b0;
         srcIdx    <= '0;
         dstIdx    <= '0;
         notOE     <= '1;
         notLoad   <= '1;
         pcInc     <= 1'b0;
         fetch_ack <= 1'b0;
         exec_ack  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= nextState;
         holdCnt   <= nextHoldCnt;
         prioExec  <= nextPrioExec;
         isExec    <= nextIsExec;
         srcIdx    <= nextSrcIdx;
         dstIdx    <= nextDstIdx;
         notOE     <= nextNotOE;
         notLoad   <= nextNotLoad;
         pcInc     <= nextPcInc;
         fetch_ack <= nextFetchAck;
         exec_ack  <= nextExecAck;
         busy      <= nextBusy;
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3, sharing clock and reset.
module tb_regfile_sequencer;

   logic       clock = 1'b0;
   logic       reset;

   logic       fetchReq1, execReq1, fetchAck1, execAck1, pcInc1, busy1;
   logic [2:0] execSrc1, execDst1;
   logic [7:0] notOE1, notLoad1;

   logic       fetchReq3, execReq3, fetchAck3, execAck3, pcInc3, busy3;
   logic [2:0] execSrc3, execDst3;
   logic [7:0] notOE3, notLoad3;

   int unsigned numChecks = 0;
   int unsigned numErrors = 0;

   always #5 clock = ~clock;

   regfile_sequencer #(.HOLD_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset),
      .fetch_req(fetchReq1), .fetch_ack(fetchAck1),
      .exec_req(execReq1), .exec_src(execSrc1), .exec_dst(execDst1), .exec_ack(execAck1),
      .notOE(notOE1), .notLoad(notLoad1), .pcInc(pcInc1), .busy(busy1)
   );

   regfile_sequencer #(.HOLD_CYCLES(3)) dut3 (
      .clock(clock), .reset(reset),
      .fetch_req(fetchReq3), .fetch_ack(fetchAck3),
      .exec_req(execReq3), .exec_src(execSrc3), .exec_dst(execDst3), .exec_ack(execAck3),
      .notOE(notOE3), .notLoad(notLoad3), .pcInc(pcInc3), .busy(busy3)
   );

   task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // fetch/exec acks must never coincide on either instance
   always @(negedge clock) begin
      if (fetchAck1 && execAck1) checkVal("ackOverlap1", 8'h1, 8'h0);
      if (fetchAck3 && execAck3) checkVal("ackOverlap3", 8'h1, 8'h0);
   end

   initial begin
      reset = 1'b1;
      fetchReq1 = 0; execReq1 = 0; execSrc1 = 0; execDst1 = 0;
      fetchReq3 = 0; execReq3 = 0; execSrc3 = 0; execDst3 = 0;

      // reset values before any clock edge
      #1;
      checkVal("rstNotOE", notOE1, 8'hFF);
      checkVal("rstNotLoad", notLoad1, 8'hFF);
      checkVal("rstFlags", {4'h0, pcInc1, fetchAck1, execAck1, busy1}, 8'h00);
      checkVal("rstNotOE3", notOE3, 8'hFF);
      step();
      reset = 1'b0;
      step();

      // lone fetch, HOLD_CYCLES=1
      fetchReq1 = 1;
      step();  // cycle 1
      fetchReq1 = 0;
      checkVal("fetchC1NotOE", notOE1, 8'h7F);
      checkVal("fetchC1Flags", {pcInc1, fetchAck1, busy1}, 8'h01);
      step();  // cycle 2
      checkVal("fetchC2NotOE", notOE1, 8'h7F);
      checkVal("fetchC2NotLoad", notLoad1, 8'hFF);
      checkVal("fetchC2Flags", {pcInc1, fetchAck1, busy1}, 8'h05);
      step();  // cycle 3
      checkVal("fetchC3NotOE", notOE1, 8'hFF);
      checkVal("fetchC3Flags", {pcInc1, fetchAck1, execAck1, busy1}, 8'h05);
      step();  // cycle 4
      checkVal("fetchC4Flags", {pcInc1, fetchAck1, execAck1, busy1}, 8'h00);

      // exec 3->5, HOLD_CYCLES=3
      execReq3 = 1; execSrc3 = 3; execDst3 = 5;
      step();
      execReq3 = 0;
      for (int c = 1; c <= 3; c++) begin
         checkVal($sformatf("exec35C%0dNotOE", c), notOE3, 8'hF7);
         checkVal($sformatf("exec35C%0dNotLoad", c), notLoad3, 8'hFF);
         step();
      end
      checkVal("exec35C4NotOE", notOE3, 8'hF7);
      checkVal("exec35C4NotLoad", notLoad3, 8'hDF);
      checkVal("exec35C4Ack", {pcInc3, execAck3}, 8'h0);
      step();
      checkVal("exec35C5Ack", {fetchAck3, execAck3}, 8'h1);
      checkVal("exec35C5NotOE", notOE3, 8'hFF);
      step();
      checkVal("exec35C6Busy", {execAck3, busy3}, 8'h0);

      // exec 0->7: loads PC register without incrementing it
      execReq1 = 1; execSrc1 = 0; execDst1 = 7;
      step();
      execReq1 = 0;
      checkVal("execPcC1NotOE", notOE1, 8'hFE);
      step();
      checkVal("execPcC2NotOE", notOE1, 8'hFE);
      checkVal("execPcC2NotLoad", notLoad1, 8'h7F);
      checkVal("execPcC2PcInc", {7'h0, pcInc1}, 8'h00);
      step();
      checkVal("execPcC3Ack", {fetchAck1, execAck1}, 8'h1);
      step();

      // operand stability: src changes 2->6 after the grant
      execReq3 = 1; execSrc3 = 2; execDst3 = 4;
      step();
      execReq3 = 0; execSrc3 = 6; execDst3 = 1;
      for (int c = 1; c <= 4; c++) begin
         checkVal($sformatf("stableC%0dNotOE", c), notOE3, 8'hFB);
         if (c == 4) checkVal("stableC4NotLoad", notLoad3, 8'hEF);
         step();
      end
      checkVal("stableAck", {fetchAck3, execAck3}, 8'h1);
      step();

      // contention: both held high, grants alternate starting with fetch
      fetchReq1 = 1; execReq1 = 1; execSrc1 = 1; execDst1 = 2;
      step();
      for (int t = 0; t < 4; t++) begin
         automatic logic wantExec = (t % 2) == 1;
         checkVal($sformatf("contT%0dNotOE", t), notOE1, wantExec ? 8'hFD : 8'h7F);
         step();
         checkVal($sformatf("contT%0dLoad", t), {pcInc1, notLoad1[2], notLoad1[7]},
                  wantExec ? 8'h01 : 8'h07);
         step();
         checkVal($sformatf("contT%0dAck", t), {fetchAck1, execAck1}, wantExec ? 8'h1 : 8'h2);
         if (t == 3) begin
            fetchReq1 = 0; execReq1 = 0;
         end
         step();
         checkVal($sformatf("contT%0dIdle", t), {fetchAck1, execAck1, busy1}, 8'h0);
         checkVal($sformatf("contT%0dIdleNotOE", t), notOE1, 8'hFF);
         step();
      end
      checkVal("contAfterBusy", {7'h0, busy1}, 8'h00);

      // reset during LOAD of an exec, request kept high
      execReq3 = 1; execSrc3 = 1; execDst3 = 2;
      step(); step(); step(); step();  // now in LOAD
      checkVal("rstMidLoadNotLoad", notLoad3, 8'hFB);
      #2;
      reset = 1'b1;
      #1;
      checkVal("rstMidNotOE", notOE3, 8'hFF);
      checkVal("rstMidNotLoad", notLoad3, 8'hFF);
      checkVal("rstMidFlags", {fetchAck3, execAck3, busy3}, 8'h0);
      step();
      checkVal("rstHeldFlags", {execAck3, busy3}, 8'h0);
      reset = 1'b0;
      step();
      checkVal("regrantNotOE", notOE3, 8'hFD);
      checkVal("regrantBusy", {7'h0, busy3}, 8'h01);
      execReq3 = 0;
      step(); step(); step();
      checkVal("regrantNotLoad", notLoad3, 8'hFB);
      step();
      checkVal("regrantAck", {fetchAck3, execAck3}, 8'h1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
